// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO with arbitrary depth, programmable thresholds and sticky errors.
// Optional high-water mark register enabled by defining FIFO_HWM_EN.
module fifo_sync_ctrl #(
    parameter int    WIDTH      = 8,
    parameter int    DEPTH      = 4,
    parameter string FWFT       = "FALSE",
    parameter int    AFULL_LVL  = DEPTH - 1,
    parameter int    AEMPTY_LVL = 1,
    localparam int   CW         = $clog2(DEPTH + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_WrEn,
    input  logic [WIDTH-1:0] i_WrData,
    input  logic             i_RdEn,
    output logic [WIDTH-1:0] o_RdData,
    input  logic             i_Flush,
    input  logic             i_ClrErr,
    output logic             o_Full,
    output logic             o_Empty,
    output logic             o_AlmostFull,
    output logic             o_AlmostEmpty,
    output logic [CW-1:0]    o_Count,
    output logic             o_OverFlow,
    output logic             o_UnderFlow,
    output logic [CW-1:0]    o_HighWater
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEP_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AE_C = CW'(AEMPTY_LVL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             full;
    logic             empty;
    logic             wr_ok;
    logic             rd_ok;
    logic             wr_err;
    logic             rd_err;

    assign full  = (count == DEP_C);
    assign empty = (count == '0);

    // Accept decisions use the pre-edge count; flush suppresses everything.
    assign wr_ok  = i_WrEn & ~full & ~i_Flush;
    assign rd_ok  = i_RdEn & ~empty & ~i_Flush;
    assign wr_err = i_WrEn & full & ~i_Flush;
    assign rd_err = i_RdEn & empty & ~i_Flush;

    assign o_Full        = full;
    assign o_Empty       = empty;
    assign o_AlmostFull  = (count >= AF_C);
    assign o_AlmostEmpty = (count <= AE_C);
    assign o_Count       = count;

    always_comb begin
        count_nxt = count;
        if (i_Flush)
            count_nxt = '0;
        else if (wr_ok && !rd_ok)
            count_nxt = count + CW'(1);
        else if (rd_ok && !wr_ok)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wp          <= '0;
            rp          <= '0;
            count       <= '0;
            o_OverFlow  <= 1'b0;
            o_UnderFlow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (i_Flush) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (wr_ok)
                    wp <= (wp == LAST) ? '0 : wp + PW'(1);
                if (rd_ok)
                    rp <= (rp == LAST) ? '0 : rp + PW'(1);
            end
            if (wr_err)
                o_OverFlow <= 1'b1;
            else if (i_ClrErr)
                o_OverFlow <= 1'b0;
            if (rd_err)
                o_UnderFlow <= 1'b1;
            else if (i_ClrErr)
                o_UnderFlow <= 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (wr_ok)
            mem[wp] <= i_WrData;
    end

    generate
        if (FWFT == "TRUE") begin : g_fwft
            // Head word shown directly; zero while nothing is stored.
            assign o_RdData = empty ? '0 : mem[rp];
        end else begin : g_std
            logic [WIDTH-1:0] rd_q;
            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst)
                    rd_q <= '0;
                else if (rd_ok)
                    rd_q <= mem[rp];
            end
            assign o_RdData = rd_q;
        end
    endgenerate

`ifdef FIFO_HWM_EN
    logic [CW-1:0] hwm;
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            hwm <= '0;
        else if (i_ClrErr)
            hwm <= count;
        else if (count_nxt > hwm)
            hwm <= count_nxt;
    end
    assign o_HighWater = hwm;
`else
    assign o_HighWater = '0;
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Scoreboard bench for fifo_sync_ctrl: depth-4 standard, depth-5 standard,
// depth-4 first-word-fall-through instances.
module tb_fifo_sync_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       wr [3];
    logic [7:0] wd [3];
    logic       rd [3];
    logic       fl [3];
    logic       ce [3];
    logic [7:0] rdat [3];
    logic       full [3];
    logic       empty [3];
    logic       af [3];
    logic       ae [3];
    logic [2:0] cnt [3];
    logic       ov [3];
    logic       un [3];
    logic [2:0] hw [3];

    int  dep [3] = '{4, 5, 4};
    bit  movf [3];
    bit  munf [3];
    int  mhw [3];
    logic [7:0] sb [$];
    int  checks = 0;
    int  errors = 0;

    fifo_sync_ctrl #(.WIDTH(8), .DEPTH(4), .FWFT("FALSE")) u0 (
        .i_Clk(clk), .i_Rst(rst), .i_WrEn(wr[0]), .i_WrData(wd[0]),
        .i_RdEn(rd[0]), .o_RdData(rdat[0]), .i_Flush(fl[0]),
        .i_ClrErr(ce[0]), .o_Full(full[0]), .o_Empty(empty[0]),
        .o_AlmostFull(af[0]), .o_AlmostEmpty(ae[0]), .o_Count(cnt[0]),
        .o_OverFlow(ov[0]), .o_UnderFlow(un[0]), .o_HighWater(hw[0])
    );

    fifo_sync_ctrl #(.WIDTH(8), .DEPTH(5), .FWFT("FALSE")) u1 (
        .i_Clk(clk), .i_Rst(rst), .i_WrEn(wr[1]), .i_WrData(wd[1]),
        .i_RdEn(rd[1]), .o_RdData(rdat[1]), .i_Flush(fl[1]),
        .i_ClrErr(ce[1]), .o_Full(full[1]), .o_Empty(empty[1]),
        .o_AlmostFull(af[1]), .o_AlmostEmpty(ae[1]), .o_Count(cnt[1]),
        .o_OverFlow(ov[1]), .o_UnderFlow(un[1]), .o_HighWater(hw[1])
    );

    fifo_sync_ctrl #(.WIDTH(8), .DEPTH(4), .FWFT("TRUE")) u2 (
        .i_Clk(clk), .i_Rst(rst), .i_WrEn(wr[2]), .i_WrData(wd[2]),
        .i_RdEn(rd[2]), .o_RdData(rdat[2]), .i_Flush(fl[2]),
        .i_ClrErr(ce[2]), .o_Full(full[2]), .o_Empty(empty[2]),
        .o_AlmostFull(af[2]), .o_AlmostEmpty(ae[2]), .o_Count(cnt[2]),
        .o_OverFlow(ov[2]), .o_UnderFlow(un[2]), .o_HighWater(hw[2])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int hw_exp(input int k);
`ifdef FIFO_HWM_EN
        return mhw[k];
`else
        return (k < 0) ? 1 : 0;
`endif
    endfunction

    task automatic status(input int k);
        chk("count", 32'(cnt[k]), 32'(sb.size()));
        chk("empty", 32'(empty[k]), 32'(sb.size() == 0));
        chk("full", 32'(full[k]), 32'(sb.size() == dep[k]));
        chk("afull", 32'(af[k]), 32'(sb.size() >= dep[k] - 1));
        chk("aempty", 32'(ae[k]), 32'(sb.size() <= 1));
        chk("ovf", 32'(ov[k]), 32'(movf[k]));
        chk("unf", 32'(un[k]), 32'(munf[k]));
    endtask

    task automatic op(input int k, input bit w, input logic [7:0] d,
                      input bit r);
        logic [7:0] exp;
        bit wa;
        bit ra;
        wa = w && (sb.size() < dep[k]);
        ra = r && (sb.size() > 0);
        exp = 8'h00;
        if (ra) exp = sb.pop_front();
        if (wa) sb.push_back(d);
        if (w && !wa) movf[k] = 1'b1;
        if (r && !ra) munf[k] = 1'b1;
        if (sb.size() > mhw[k]) mhw[k] = sb.size();
        wr[k] = w;
        wd[k] = d;
        rd[k] = r;
        @(posedge clk);
        #1;
        wr[k] = 1'b0;
        rd[k] = 1'b0;
        status(k);
        if (k != 2 && ra) chk("rdata", 32'(rdat[k]), 32'(exp));
        if (k == 2 && sb.size() > 0) chk("fwft", 32'(rdat[k]), 32'(sb[0]));
    endtask

    task automatic clr(input int k);
        ce[k] = 1'b1;
        @(posedge clk);
        #1;
        ce[k] = 1'b0;
        movf[k] = 1'b0;
        munf[k] = 1'b0;
        mhw[k] = sb.size();
        status(k);
    endtask

    task automatic flush(input int k, input bit w);
        fl[k] = 1'b1;
        wr[k] = w;
        wd[k] = 8'hEE;
        @(posedge clk);
        #1;
        fl[k] = 1'b0;
        wr[k] = 1'b0;
        sb.delete();
        status(k);
        chk("hwm_flush", 32'(hw[k]), 32'(hw_exp(k)));
    endtask

    task automatic chk_reset(input int k);
        chk("rst_count", 32'(cnt[k]), 0);
        chk("rst_empty", 32'(empty[k]), 1);
        chk("rst_full", 32'(full[k]), 0);
        chk("rst_aempty", 32'(ae[k]), 1);
        chk("rst_afull", 32'(af[k]), 0);
        chk("rst_rdata", 32'(rdat[k]), 0);
        chk("rst_ovf", 32'(ov[k]), 0);
        chk("rst_unf", 32'(un[k]), 0);
        chk("rst_hwm", 32'(hw[k]), 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            wr[i] = 1'b0; wd[i] = 8'h00; rd[i] = 1'b0;
            fl[i] = 1'b0; ce[i] = 1'b0;
            movf[i] = 1'b0; munf[i] = 1'b0; mhw[i] = 0;
        end
        #12;
        for (int i = 0; i < 3; i++) chk_reset(i);
        rst = 1'b0;

        // Fill and drain, depth 4 standard read
        for (int i = 1; i <= 4; i++) op(0, 1'b1, 8'(i * 8'h11), 1'b0);
        for (int i = 0; i < 4; i++) op(0, 1'b0, 8'h00, 1'b1);

        // Write while full with simultaneous read
        for (int i = 0; i < 4; i++) op(0, 1'b1, 8'(8'h55 + i), 1'b0);
        op(0, 1'b1, 8'hEE, 1'b1);
        clr(0);
        for (int i = 0; i < 3; i++) op(0, 1'b0, 8'h00, 1'b1);

        // Read while empty with simultaneous write
        op(0, 1'b1, 8'hA5, 1'b1);
        op(0, 1'b0, 8'h00, 1'b1);
        clr(0);

        // Depth 5: wrap pointers several times
        for (int i = 0; i < 3; i++) op(1, 1'b1, 8'(i), 1'b0);
        for (int i = 3; i < 15; i++) op(1, 1'b1, 8'(i), 1'b1);
        op(1, 1'b1, 8'd15, 1'b0);
        op(1, 1'b1, 8'd16, 1'b0);
        op(1, 1'b1, 8'd99, 1'b0);
        clr(1);
        for (int i = 0; i < 5; i++) op(1, 1'b0, 8'h00, 1'b1);

        // First-word-fall-through
        op(2, 1'b1, 8'h5A, 1'b0);
        op(2, 1'b0, 8'h00, 1'b1);
        op(2, 1'b1, 8'h3C, 1'b0);
        op(2, 1'b1, 8'hC3, 1'b0);
        op(2, 1'b0, 8'h00, 1'b1);
        op(2, 1'b0, 8'h00, 1'b1);

        // Flush with a concurrent write, then async reset mid-burst
        for (int i = 0; i < 3; i++) op(0, 1'b1, 8'(8'h70 + i), 1'b0);
        op(0, 1'b0, 8'h00, 1'b0);
        flush(0, 1'b1);
        op(0, 1'b0, 8'h00, 1'b1);
        op(0, 1'b1, 8'h81, 1'b0);
        op(0, 1'b1, 8'h82, 1'b1);
        wr[0] = 1'b1;
        wd[0] = 8'h83;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        wr[0] = 1'b0;
        chk_reset(0);
        sb.delete();
        movf[0] = 1'b0;
        munf[0] = 1'b0;
        mhw[0] = 0;
        @(negedge clk);
        rst = 1'b0;
        op(0, 1'b1, 8'h9D, 1'b0);
        op(0, 1'b0, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
